// File: rtl/gemm_stream_host.sv
// Stream front end for the GEMM engine: gathers alpha, beta, A, B, C from a word stream,
// resets and starts the engine, captures the result and streams it back row-major.
module gemm_stream_host #(
  parameter int DATA_WIDTH    = 64,
  parameter int MATRIX_WIDTH  = 4,
  parameter int MATRIX_HEIGHT = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic                   iclk,
  input  logic                   irst,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   ogemm_rst,
  output logic                   ostart,
  output logic signed [DATA_WIDTH-1:0] oalpha,
  output logic signed [DATA_WIDTH-1:0] obeta,
  output logic signed [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] oa_matrix,
  output logic signed [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] ob_matrix,
  output logic signed [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] oc_matrix,
  input  logic signed [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] iresult_matrix,
  input  logic                   ibusy,
  input  logic                   idone,
  output logic                   obusy,
  output logic                   oerror
);

  localparam int HW     = MATRIX_HEIGHT * MATRIX_WIDTH;
  localparam int NWORDS = 2 + 3 * HW;
  localparam int IDX_W  = $clog2(NWORDS);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int SLOT_W = (HW > 1) ? $clog2(HW) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);
  localparam logic [IDX_W-1:0] A_BASE   = IDX_W'(2);
  localparam logic [IDX_W-1:0] B_BASE   = IDX_W'(2 + HW);
  localparam logic [IDX_W-1:0] C_BASE   = IDX_W'(2 + 2 * HW);
  localparam logic [IDX_W-1:0] OUT_LAST = IDX_W'(HW - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] ST_LOAD  = 3'd0;
  localparam logic [2:0] ST_GRST  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             cap;
  logic             load_hs;
  logic [IDX_W-1:0] off;
  logic [SLOT_W-1:0] slot;

  logic signed [DATA_WIDTH-1:0]         alpha_q, beta_q;
  logic signed [HW-1:0][DATA_WIDTH-1:0] a_q, b_q, c_q, res_q;

  // The engine status is not needed: idone alone ends the wait.
  logic unused_ibusy;
  assign unused_ibusy = ibusy;

  assign in_ready  = (state_q == ST_LOAD) && !irst;
  assign load_hs   = in_valid && in_ready;
  assign out_valid = (state_q == ST_DRAIN);
  assign out_last  = (state_q == ST_DRAIN) && (idx_q == OUT_LAST);
  assign out_data  = res_q[SLOT_W'(idx_q)];
  assign ogemm_rst = irst || (state_q == ST_GRST);
  assign ostart    = (state_q == ST_START);
  assign obusy     = (state_q != ST_LOAD);
  assign oerror    = err_q;

  assign oalpha    = alpha_q;
  assign obeta     = beta_q;
  assign oa_matrix = a_q;
  assign ob_matrix = b_q;
  assign oc_matrix = c_q;

  // Offset of the current word within whichever matrix it belongs to.
  always_comb begin
    off = idx_q - A_BASE;
    if (idx_q >= C_BASE) begin
      off = idx_q - C_BASE;
    end else if (idx_q >= B_BASE) begin
      off = idx_q - B_BASE;
    end
  end
  assign slot = SLOT_W'(off);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    cap     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (load_hs) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_GRST;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_GRST:  state_d = ST_START;
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the last allowed cycle still counts as success.
        if (idone) begin
          cap     = 1'b1;
          state_d = ST_DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (idx_q == OUT_LAST) begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      alpha_q <= '0;
      beta_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (load_hs) begin
        if (idx_q == '0) begin
          alpha_q <= in_data;
        end else if (idx_q == IDX_W'(1)) begin
          beta_q <= in_data;
        end else if (idx_q < B_BASE) begin
          a_q[slot] <= in_data;
        end else if (idx_q < C_BASE) begin
          b_q[slot] <= in_data;
        end else begin
          c_q[slot] <= in_data;
        end
      end
      if (cap) begin
        res_q <= iresult_matrix;
      end
    end
  end

endmodule

// File: tb/tb_gemm_stream_host.sv
// Directed bench for gemm_stream_host: two instances (default and short timeout) driven
// through a select mux, with a behavioural engine computing alpha*A*B + beta*C.
module tb_gemm_stream_host;

  localparam int DW = 64;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int HW = 16;
  localparam int NW = 50;

  typedef logic signed [H-1:0][W-1:0][DW-1:0] mat_t;

  logic iclk = 1'b0;
  logic irst;
  logic sel;
  logic in_valid;
  logic [DW-1:0] in_data;
  logic out_ready;

  logic in_valid_a, in_valid_b, out_ready_a, out_ready_b, idone_a, idone_b;
  logic in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_last_a, out_last_b;
  logic ogemm_rst_a, ogemm_rst_b, ostart_a, ostart_b, obusy_a, obusy_b, oerror_a, oerror_b;
  logic [DW-1:0] out_data_a, out_data_b;
  logic signed [DW-1:0] oalpha_a, oalpha_b, obeta_a, obeta_b;
  mat_t oa_a, oa_b, ob_a, ob_b, oc_a, oc_b;

  logic in_ready, out_valid, out_last, ogemm_rst, ostart, obusy, oerror;
  logic [DW-1:0] out_data;
  logic signed [DW-1:0] oalpha, obeta;
  mat_t oa_m, ob_m, oc_m, eng_res;

  logic idone, eng_run, eng_never;
  int   eng_cnt, eng_d;
  logic signed [DW-1:0] acc;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [DW-1:0] job_w [NW];
  logic [DW-1:0] exp_r [HW];
  logic aborted;

  always #5 iclk = ~iclk;

  assign in_valid_a  = in_valid & ~sel;
  assign in_valid_b  = in_valid & sel;
  assign out_ready_a = out_ready | sel;
  assign out_ready_b = out_ready | ~sel;
  assign idone_a     = idone & ~sel;
  assign idone_b     = idone & sel;

  assign in_ready  = sel ? in_ready_b  : in_ready_a;
  assign out_valid = sel ? out_valid_b : out_valid_a;
  assign out_data  = sel ? out_data_b  : out_data_a;
  assign out_last  = sel ? out_last_b  : out_last_a;
  assign ogemm_rst = sel ? ogemm_rst_b : ogemm_rst_a;
  assign ostart    = sel ? ostart_b    : ostart_a;
  assign obusy     = sel ? obusy_b     : obusy_a;
  assign oerror    = sel ? oerror_b    : oerror_a;
  assign oalpha    = sel ? oalpha_b    : oalpha_a;
  assign obeta     = sel ? obeta_b     : obeta_a;
  assign oa_m      = sel ? oa_b        : oa_a;
  assign ob_m      = sel ? ob_b        : ob_a;
  assign oc_m      = sel ? oc_b        : oc_a;

  gemm_stream_host u_dut_a (
    .iclk(iclk), .irst(irst),
    .in_valid(in_valid_a), .in_data(in_data), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_last(out_last_a), .out_ready(out_ready_a),
    .ogemm_rst(ogemm_rst_a), .ostart(ostart_a), .oalpha(oalpha_a), .obeta(obeta_a),
    .oa_matrix(oa_a), .ob_matrix(ob_a), .oc_matrix(oc_a), .iresult_matrix(eng_res),
    .ibusy(eng_run), .idone(idone_a), .obusy(obusy_a), .oerror(oerror_a)
  );

  gemm_stream_host #(.TIMEOUT(8)) u_dut_b (
    .iclk(iclk), .irst(irst),
    .in_valid(in_valid_b), .in_data(in_data), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_last(out_last_b), .out_ready(out_ready_b),
    .ogemm_rst(ogemm_rst_b), .ostart(ostart_b), .oalpha(oalpha_b), .obeta(obeta_b),
    .oa_matrix(oa_b), .ob_matrix(ob_b), .oc_matrix(oc_b), .iresult_matrix(eng_res),
    .ibusy(eng_run), .idone(idone_b), .obusy(obusy_b), .oerror(oerror_b)
  );

  // Engine model: done pulses eng_d cycles after start.
  always @(posedge iclk) begin
    if (irst) begin
      eng_run <= 1'b0;
      eng_cnt <= 0;
    end else if (ostart) begin
      eng_run <= 1'b1;
      eng_cnt <= 1;
    end else if (eng_run) begin
      if (eng_cnt == eng_d) eng_run <= 1'b0;
      eng_cnt <= eng_cnt + 1;
    end
  end
  assign idone = eng_run && (eng_cnt == eng_d) && !eng_never;

  always_comb begin
    eng_res = '0;
    acc     = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        acc = obeta * oc_m[r][c];
        for (int k = 0; k < W; k++) acc = acc + oalpha * oa_m[r][k] * ob_m[k][c];
        eng_res[r][c] = acc;
      end
    end
  end

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] expv);
    vec_cnt++;
    if (got !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic load_job(input int alpha, input int beta, input int a_diag, input int b_off,
                          input int c_mul, input int c_add);
    job_w[0] = 64'(alpha);
    job_w[1] = 64'(beta);
    for (int k = 0; k < HW; k++) begin
      job_w[2 + k]        = ((k / W) == (k % W)) ? 64'(a_diag) : 64'd0;
      job_w[2 + HW + k]   = 64'(k + b_off);
      job_w[2 + 2*HW + k] = 64'(k * c_mul + c_add);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_in_ready"},  64'(in_ready), 64'd0);
    check_val({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_val({tag, "_out_last"},  64'(out_last), 64'd0);
    check_val({tag, "_ostart"},    64'(ostart), 64'd0);
    check_val({tag, "_oerror"},    64'(oerror), 64'd0);
    check_val({tag, "_ogemm_rst"}, 64'(ogemm_rst), 64'd1);
    check_val({tag, "_obusy"},     64'(obusy), 64'd0);
    check_val({tag, "_alpha"},     oalpha, 64'd0);
    check_val({tag, "_a00"},       oa_m[0][0], 64'd0);
    check_val({tag, "_b33"},       ob_m[3][3], 64'd0);
  endtask

  task automatic send_job(input int pause_at, input int pause_len, input int rst_at,
                          output logic ab);
    int g;
    ab = 1'b0;
    for (int i = 0; i < NW; i++) begin
      @(negedge iclk);
      if (i == rst_at) begin
        in_valid = 1'b0;
        irst = 1'b1;
        @(negedge iclk);
        check_reset("midrst");
        irst = 1'b0;
        ab = 1'b1;
        return;
      end
      if (i == pause_at) begin
        in_valid = 1'b0;
        repeat (pause_len) begin
          check_val("pause_ostart", 64'(ostart), 64'd0);
          check_val("pause_ready", 64'(in_ready), 64'd1);
          @(negedge iclk);
        end
      end
      in_valid = 1'b1;
      in_data  = job_w[i];
      g = 0;
      while (!in_ready && g < 50) begin
        @(negedge iclk);
        g++;
      end
      if (g >= 50) check_val("in_ready_wait", 64'(in_ready), 64'd1);
    end
    @(negedge iclk);
    in_valid = 1'b0;
    check_val("grst_rst", 64'(ogemm_rst), 64'd1);
    check_val("grst_nostart", 64'(ostart), 64'd0);
    check_val("grst_busy", 64'(obusy), 64'd1);
    @(negedge iclk);
    check_val("start_pulse", 64'(ostart), 64'd1);
    check_val("start_rst", 64'(ogemm_rst), 64'd0);
    check_val("op_alpha", oalpha, job_w[0]);
    check_val("op_beta", obeta, job_w[1]);
    for (int k = 0; k < HW; k++) begin
      check_val("op_a", oa_m[k / W][k % W], job_w[2 + k]);
      check_val("op_b", ob_m[k / W][k % W], job_w[2 + HW + k]);
      check_val("op_c", oc_m[k / W][k % W], job_w[2 + 2*HW + k]);
    end
  endtask

  task automatic wait_result(input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge iclk);
      n++;
      if (!out_valid && ostart) check_val("wait_restart", 64'(ostart), 64'd0);
    end while (!out_valid && n < 3000);
    check_val("done_latency", 64'(n), 64'(exp_lat));
  endtask

  task automatic drain(input logic stall_mode);
    logic [3:0] pat;
    logic [DW-1:0] prev;
    logic stalled;
    int n, j;
    pat = 4'b1001;
    prev = '0;
    stalled = 1'b0;
    n = 0;
    j = 0;
    while (n < HW && j < 200) begin
      out_ready = stall_mode ? pat[j[1:0]] : 1'b1;
      check_val("drain_valid", 64'(out_valid), 64'd1);
      if (stalled) check_val("drain_hold", out_data, prev);
      check_val("drain_data", out_data, exp_r[n]);
      check_val("drain_last", 64'(out_last), 64'(n == HW - 1));
      if (out_ready) begin
        n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        prev = out_data;
      end
      j++;
      if (n < HW) @(negedge iclk);
    end
    check_val("drain_count", 64'(n), 64'(HW));
    @(negedge iclk);
    out_ready = 1'b1;
    check_val("post_valid", 64'(out_valid), 64'd0);
    check_val("post_ready", 64'(in_ready), 64'd1);
    check_val("post_busy", 64'(obusy), 64'd0);
  endtask

  initial begin
    sel = 1'b0;
    irst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    eng_d = 20;
    eng_never = 1'b0;
    repeat (3) @(negedge iclk);
    check_reset("reset");
    irst = 1'b0;

    // Identity times 1..16 returns 1..16.
    load_job(1, 0, 1, 1, 0, 0);
    for (int k = 0; k < HW; k++) exp_r[k] = 64'(k + 1);
    send_job(-1, 0, -1, aborted);
    wait_result(21);
    drain(1'b0);
    check_val("t1_err", 64'(oerror), 64'd0);

    // Five idle cycles mid-load; result is B + C.
    load_job(1, 1, 1, 10, 1000, 0);
    for (int k = 0; k < HW; k++) exp_r[k] = 64'(k + 10 + 1000 * k);
    send_job(20, 5, -1, aborted);
    wait_result(21);
    drain(1'b0);

    // Negative identity with downstream stalls.
    load_job(1, 0, -1, 1, 0, 0);
    for (int k = 0; k < HW; k++) exp_r[k] = 64'(-(k + 1));
    send_job(-1, 0, -1, aborted);
    wait_result(21);
    drain(1'b1);

    // Reset at word 30, then a full job.
    load_job(1, 0, 1, 1, 0, 0);
    send_job(-1, 0, 30, aborted);
    check_val("t6_aborted", 64'(aborted), 64'd1);
    load_job(1, 1, 1, 10, 1000, 0);
    for (int k = 0; k < HW; k++) exp_r[k] = 64'(k + 10 + 1000 * k);
    send_job(-1, 0, -1, aborted);
    wait_result(21);
    drain(1'b0);
    check_val("t6_err", 64'(oerror), 64'd0);

    // Short-timeout instance: done on the final allowed cycle.
    @(negedge iclk);
    sel = 1'b1;
    eng_d = 8;
    load_job(2, 1, 1, 1, 0, 100);
    for (int k = 0; k < HW; k++) exp_r[k] = 64'(2 * k + 102);
    send_job(-1, 0, -1, aborted);
    wait_result(9);
    drain(1'b0);
    check_val("t5_err", 64'(oerror), 64'd0);

    // Engine never finishes.
    eng_never = 1'b1;
    load_job(1, 0, 1, 1, 0, 0);
    send_job(-1, 0, -1, aborted);
    for (int n = 1; n <= 9; n++) begin
      @(negedge iclk);
      check_val("t4_noout", 64'(out_valid), 64'd0);
      if (n == 8) begin
        check_val("t4_err_pre", 64'(oerror), 64'd0);
        check_val("t4_busy_pre", 64'(obusy), 64'd1);
      end
    end
    check_val("t4_err", 64'(oerror), 64'd1);
    check_val("t4_ready", 64'(in_ready), 64'd1);

    // Error is sticky across a following good job.
    eng_never = 1'b0;
    eng_d = 3;
    for (int k = 0; k < HW; k++) exp_r[k] = 64'(k + 1);
    send_job(-1, 0, -1, aborted);
    wait_result(4);
    drain(1'b0);
    check_val("t4_sticky", 64'(oerror), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
